wb_arbiter: RTL and testbench

Write-back arbiter between the pipeline's MEM/WB stage, the multi-cycle multiply/divide unit and the register file's single write port. Every cycle it drives at most one register write, with the in-order pipeline taking strict priority. Multiply/divide results wait in a small FIFO until the port is free. A destination scoreboard lets the hazard unit stall readers of registers whose multiply/divide result has not yet been written.

---
 rtl/wb_arbiter_if.sv | 35 +++
 rtl/wb_arbiter.sv | 93 +++++++++
 tb/tb_wb_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Write-back arbiter bus: pipeline and multiply/divide write requests in,
// register-file write port, FIFO status and destination scoreboard out.
interface wb_arbiter_if #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
);
    logic                     pipeRegWrite;
    logic [4:0]               pipeWriteReg;
    logic [WIDTH-1:0]         pipeWriteData;
    logic                     mdValid;
    logic [4:0]               mdReg;
    logic [WIDTH-1:0]         mdData;
    logic                     mdReady;
    logic                     issueValid;
    logic [4:0]               issueReg;
    logic                     regWrite;
    logic [4:0]               WriteReg;
    logic [WIDTH-1:0]         writeData;
    logic [31:0]              busy;
    logic [$clog2(DEPTH):0]   fifoCount;

    modport master (
        output pipeRegWrite, pipeWriteReg, pipeWriteData,
        output mdValid, mdReg, mdData,
        output issueValid, issueReg,
        input  mdReady, regWrite, WriteReg, writeData, busy, fifoCount
    );

    modport slave (
        input  pipeRegWrite, pipeWriteReg, pipeWriteData,
        input  mdValid, mdReg, mdData,
        input  issueValid, issueReg,
        output mdReady, regWrite, WriteReg, writeData, busy, fifoCount
    );
endinterface

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: the in-order pipeline has strict priority,
// multiply/divide results queue in a small FIFO, and a scoreboard tracks them.
module wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [4:0]       dest;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  rdPtr, wrPtr;
    logic [CNT_W-1:0]  count;
    logic              notFull;

    logic              regWriteQ;
    logic [4:0]        writeRegQ;
    logic [WIDTH-1:0]  writeDataQ;
    logic [31:0]       busyQ;

    logic              pipeTake, push, pop;
    entry_t            head;
    logic [31:0]       setMask, clrMask;

    assign notFull = (count != CNT_W'(DEPTH));

    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        pipeTake = bus.pipeRegWrite && (bus.pipeWriteReg != 5'd0);
        push     = bus.mdValid && notFull;
        pop      = !pipeTake && (count != '0);
        head     = mem[rdPtr];
        setMask  = '0;
        clrMask  = '0;
        if (bus.issueValid && (bus.issueReg != 5'd0)) setMask[bus.issueReg] = 1'b1;
        if (pop) clrMask[head.dest] = 1'b1;
    end

    // NOTE: FIFO storage is not reset; entries are only ever read behind the count, so clearing them would be wasted logic.
    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= '{dest: bus.mdReg, data: bus.mdData};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdPtr      <= '0;
            wrPtr      <= '0;
            count      <= '0;
            busyQ      <= '0;
            regWriteQ  <= 1'b0;
            writeRegQ  <= '0;
            writeDataQ <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // Set is applied after clear so a re-issue on the popping edge keeps the bit.
            busyQ <= ((busyQ & ~clrMask) | setMask) & ~32'd1;

            if (pipeTake) begin
                regWriteQ  <= 1'b1;
                writeRegQ  <= bus.pipeWriteReg;
                writeDataQ <= bus.pipeWriteData;
            end else if (pop) begin
                regWriteQ  <= (head.dest != 5'd0);
                writeRegQ  <= head.dest;
                writeDataQ <= head.data;
            end else begin
                regWriteQ  <= 1'b0;
            end
        end
    end

    assign bus.mdReady   = notFull;
    assign bus.fifoCount = count;
    assign bus.regWrite  = regWriteQ;
    assign bus.WriteReg  = writeRegQ;
    assign bus.writeData = writeDataQ;
    assign bus.busy      = busyQ;
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: a queue-based reference model checked every
// negedge, plus directed scenarios with literal expectations.
module tb_wb_arbiter;
    localparam int DEPTH = 2;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_arbiter_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();
    wb_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } mdres_t;

    mdres_t      mdPend[$];
    mdres_t      modelQ[$];
    logic        expRegWrite  = 1'b0;
    logic [4:0]  expWriteReg  = '0;
    logic [31:0] expWriteData = '0;
    logic [31:0] expBusy      = '0;
    int          vectors      = 0;
    int          miscompares  = 0;
    bit          checkEn      = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: strict pipe priority, in-order queue, busy set-over-clear.
    mdres_t popped;
    bit     canPush, didPop;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            modelQ.delete();
            expRegWrite  = 1'b0;
            expWriteReg  = '0;
            expWriteData = '0;
            expBusy      = '0;
        end else begin
            canPush = (modelQ.size() != DEPTH);
            didPop  = 1'b0;
            if (bus.pipeRegWrite && bus.pipeWriteReg != 0) begin
                expRegWrite  = 1'b1;
                expWriteReg  = bus.pipeWriteReg;
                expWriteData = bus.pipeWriteData;
            end else if (modelQ.size() > 0) begin
                popped       = modelQ.pop_front();
                didPop       = 1'b1;
                expRegWrite  = (popped.r != 0);
                expWriteReg  = popped.r;
                expWriteData = popped.d;
            end else begin
                expRegWrite  = 1'b0;
            end
            if (bus.mdValid && canPush) modelQ.push_back('{r: bus.mdReg, d: bus.mdData});
            if (didPop) expBusy[popped.r] = 1'b0;
            if (bus.issueValid && bus.issueReg != 0) expBusy[bus.issueReg] = 1'b1;
            expBusy[0] = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            check("regWrite",  bus.regWrite,  expRegWrite);
            check("WriteReg",  bus.WriteReg,  expWriteReg);
            check("writeData", bus.writeData, expWriteData);
            check("busy",      bus.busy,      expBusy);
            check("fifoCount", bus.fifoCount, modelQ.size());
            check("mdReady",   bus.mdReady,   modelQ.size() != DEPTH);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One clock cycle of stimulus; the pending md result is held until accepted.
    task automatic cycle(input bit pv, input logic [4:0] pr, input logic [31:0] pd,
                         input bit iv, input logic [4:0] ir);
        bit rdy;
        bus.pipeRegWrite  = pv;
        bus.pipeWriteReg  = pr;
        bus.pipeWriteData = pd;
        bus.issueValid    = iv;
        bus.issueReg      = ir;
        if (mdPend.size() > 0) begin
            bus.mdValid = 1'b1;
            bus.mdReg   = mdPend[0].r;
            bus.mdData  = mdPend[0].d;
        end else begin
            bus.mdValid = 1'b0;
            bus.mdReg   = '0;
            bus.mdData  = '0;
        end
        rdy = bus.mdReady;
        @(posedge clk);
        #2;
        if (bus.mdValid && rdy) void'(mdPend.pop_front());
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    endtask

    initial begin
        bus.pipeRegWrite = 1'b0; bus.pipeWriteReg = '0; bus.pipeWriteData = '0;
        bus.mdValid = 1'b0; bus.mdReg = '0; bus.mdData = '0;
        bus.issueValid = 1'b0; bus.issueReg = '0;

        #3 rst = 1'b0;
        checkEn = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("rst regWrite",  bus.regWrite,  0);
        check("rst fifoCount", bus.fifoCount, 0);
        check("rst mdReady",   bus.mdReady,   1);
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #2;

        // Pipe wins over a same-edge md push; md result follows on the idle edge.
        mdPend.push_back('{r: 5'd7, d: 32'h1234});
        cycle(1'b1, 5'd3, 32'hAAAA5555, 1'b0, 5'd0);
        check("prio wreg",  bus.WriteReg,  3);
        check("prio wdata", bus.writeData, 32'hAAAA5555);
        check("prio count", bus.fifoCount, 1);
        idle();
        check("prio md wreg",  bus.WriteReg,  7);
        check("prio md wdata", bus.writeData, 32'h1234);
        check("prio md we",    bus.regWrite,  1);

        // Scoreboard set, clear on pop, and set winning over a same-edge clear.
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
        check("sb set", bus.busy[9], 1);
        mdPend.push_back('{r: 5'd9, d: 32'h99});
        idle();
        idle();
        check("sb clear", bus.busy[9], 0);
        mdPend.push_back('{r: 5'd9, d: 32'h9A});
        idle();
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
        check("sb set wins", bus.busy[9], 1);
        check("sb set wins wreg", bus.WriteReg, 9);
        mdPend.push_back('{r: 5'd9, d: 32'h9B});
        idle();
        idle();
        check("sb clear again", bus.busy, 0);

        // r0 handling on both paths.
        mdPend.push_back('{r: 5'd12, d: 32'hC});
        idle();
        cycle(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0);
        check("r0 pipe pop wreg",  bus.WriteReg,  12);
        check("r0 pipe pop wdata", bus.writeData, 32'hC);
        check("r0 pipe pop count", bus.fifoCount, 0);
        mdPend.push_back('{r: 5'd0, d: 32'h55});
        idle();
        idle();
        check("r0 md we",   bus.regWrite, 0);
        check("r0 md busy", bus.busy,     0);

        // Simultaneous push and pop at count 1.
        mdPend.push_back('{r: 5'd10, d: 32'hA0});
        idle();
        mdPend.push_back('{r: 5'd11, d: 32'hB0});
        idle();
        check("pp count", bus.fifoCount, 1);
        check("pp wreg",  bus.WriteReg,  10);
        idle();
        check("pp wreg2", bus.WriteReg,  11);
        check("pp count2", bus.fifoCount, 0);

        // Backpressure and pointer wrap under six busy pipe cycles.
        mdPend.push_back('{r: 5'd20, d: 32'h20});
        mdPend.push_back('{r: 5'd21, d: 32'h21});
        mdPend.push_back('{r: 5'd22, d: 32'h22});
        for (int i = 1; i <= 6; i++) cycle(1'b1, 5'(i), 32'(i), 1'b0, 5'd0);
        check("bp count", bus.fifoCount, 2);
        check("bp ready", bus.mdReady,   0);
        check("bp wreg",  bus.WriteReg,  6);
        idle();
        check("bp pop1", bus.WriteReg,  20);
        check("bp c1",   bus.fifoCount, 1);
        idle();
        check("bp pop2", bus.WriteReg,  21);
        check("bp c2",   bus.fifoCount, 1);
        idle();
        check("bp pop3",  bus.WriteReg,  22);
        check("bp data3", bus.writeData, 32'h22);
        idle();
        check("bp idle we", bus.regWrite, 0);

        // Asynchronous reset mid-run with two queued results and busy[5] set.
        mdPend.push_back('{r: 5'd13, d: 32'h13});
        mdPend.push_back('{r: 5'd14, d: 32'h14});
        cycle(1'b1, 5'd1, 32'h1, 1'b1, 5'd5);
        cycle(1'b1, 5'd2, 32'h2, 1'b0, 5'd0);
        check("pre-rst count", bus.fifoCount, 2);
        check("pre-rst busy5", bus.busy[5],   1);
        #1 rst = 1'b0;
        #1;
        check("arst regWrite",  bus.regWrite,  0);
        check("arst WriteReg",  bus.WriteReg,  0);
        check("arst writeData", bus.writeData, 0);
        check("arst busy",      bus.busy,      0);
        check("arst fifoCount", bus.fifoCount, 0);
        check("arst mdReady",   bus.mdReady,   1);
        mdPend.delete();
        bus.pipeRegWrite = 1'b0; bus.mdValid = 1'b0; bus.issueValid = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #2;
        mdPend.push_back('{r: 5'd15, d: 32'h15});
        idle();
        idle();
        check("post-rst wreg", bus.WriteReg, 15);
        idle();

        checkEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
